// File: rtl/cycle_pkg.sv
// rtl/cycle_pkg.sv - shared types and constants for the machine-cycle controller
//
// Holds the machine-state encoding, the opcode values, the ALU_OP codes
// and the packed strobe record driven by op_decode.
package cycle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [3:0] OPC_NOP = 4'h0;
    localparam logic [3:0] OPC_LDA = 4'h1;
    localparam logic [3:0] OPC_ADD = 4'h2;
    localparam logic [3:0] OPC_SUB = 4'h3;
    localparam logic [3:0] OPC_STA = 4'h4;
    localparam logic [3:0] OPC_JMP = 4'h5;
    localparam logic [3:0] OPC_JZ  = 4'h6;
    localparam logic [3:0] OPC_HLT = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef struct packed {
        logic       pc_oe;
        logic       pc_inc;
        logic       pc_ld;
        logic       mar_ld;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_ld;
        logic       acc_ld;
        logic [1:0] alu_op;
    } strobe_t;

    localparam strobe_t STROBE_NONE = '0;

    // True when exactly one beat line is high.
    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Index of the highest set beat line; only meaningful when one-hot.
    function automatic logic [2:0] beat_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/op_decode.sv
// rtl/op_decode.sv - beat-level strobe decoder
//
// Ports:
//   state   : current machine state
//   opcode  : opcode latched at the end of FETCH
//   zf      : zero flag latched at the end of FETCH
//   beat    : index 0..7 of the active beat
//   strobe  : control strobes and ALU_OP for this beat
module op_decode
    import cycle_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  state_t          state,
    input  logic [OP_W-1:0] opcode,
    input  logic            zf,
    input  logic [2:0]      beat,
    output strobe_t         strobe
);

    always_comb begin
        strobe = STROBE_NONE;
        case (state)
            ST_FETCH: begin
                case (beat)
                    3'd0: begin
                        strobe.pc_oe  = 1'b1;
                        strobe.mar_ld = 1'b1;
                    end
                    3'd1: begin
                        strobe.mem_rd = 1'b1;
                        strobe.ir_ld  = 1'b1;
                    end
                    3'd2: strobe.pc_inc = 1'b1;
                    default: ;
                endcase
            end
            ST_EXEC: begin
                case (opcode)
                    OP_W'(OPC_LDA), OP_W'(OPC_ADD), OP_W'(OPC_SUB): begin
                        if (beat == 3'd0) begin
                            strobe.mar_ld = 1'b1;
                        end else if (beat == 3'd1) begin
                            strobe.mem_rd = 1'b1;
                            strobe.acc_ld = 1'b1;
                            if (opcode == OP_W'(OPC_ADD))
                                strobe.alu_op = ALU_ADD;
                            else if (opcode == OP_W'(OPC_SUB))
                                strobe.alu_op = ALU_SUB;
                            else
                                strobe.alu_op = ALU_PASS;
                        end
                    end
                    OP_W'(OPC_STA): begin
                        if (beat == 3'd0)
                            strobe.mar_ld = 1'b1;
                        else if (beat == 3'd1)
                            strobe.mem_wr = 1'b1;
                    end
                    OP_W'(OPC_JMP): begin
                        if (beat == 3'd0)
                            strobe.pc_ld = 1'b1;
                    end
                    OP_W'(OPC_JZ): begin
                        if (beat == 3'd0 && zf)
                            strobe.pc_ld = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cycle_ctrl.sv
// rtl/cycle_ctrl.sv - machine-cycle controller (IDLE/FETCH/EXEC/HALT sequencer)
//
// Ports:
//   CLK, CLRn        : clock, asynchronous active-low reset
//   T0..T7           : one-hot beat pulses
//   RUN              : start request, honoured only in IDLE
//   IR_OP, ZF        : opcode field and accumulator zero flag
//   PC_OE..ACC_LD    : register/memory strobes, combinational per beat
//   ALU_OP           : 00 PASS, 01 ADD, 10 SUB
//   CYCLE, HALTED    : machine state and halt indication
//   PHASE_ERR        : sticky beat-encoding error
//   INSTR_CNT        : number of completed EXEC cycles
module cycle_ctrl
    import cycle_pkg::*;
#(
    parameter int OP_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             CLRn,
    input  logic             T0,
    input  logic             T1,
    input  logic             T2,
    input  logic             T3,
    input  logic             T4,
    input  logic             T5,
    input  logic             T6,
    input  logic             T7,
    input  logic             RUN,
    input  logic [OP_W-1:0]  IR_OP,
    input  logic             ZF,
    output logic             PC_OE,
    output logic             PC_INC,
    output logic             PC_LD,
    output logic             MAR_LD,
    output logic             MEM_RD,
    output logic             MEM_WR,
    output logic             IR_LD,
    output logic             ACC_LD,
    output logic [1:0]       ALU_OP,
    output logic [1:0]       CYCLE,
    output logic             HALTED,
    output logic             PHASE_ERR,
    output logic [CNT_W-1:0] INSTR_CNT
);

    logic [7:0]      beats;
    logic            beat_ok;
    logic [2:0]      beat;
    state_t          state;
    logic [OP_W-1:0] op_q;
    logic            zf_q;
    logic [CNT_W-1:0] cnt;
    logic            err;
    strobe_t         dec;
    strobe_t         strobe;

    assign beats   = {T7, T6, T5, T4, T3, T2, T1, T0};
    assign beat_ok = is_onehot8(beats);
    assign beat    = beat_index(beats);

    // State only moves on the T7 edge closing a machine cycle. A bad beat
    // pattern latches the error and from then on nothing moves until reset.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state <= ST_IDLE;
            op_q  <= '0;
            zf_q  <= 1'b0;
            cnt   <= '0;
            err   <= 1'b0;
        end else if (!err) begin
            if (!beat_ok) begin
                err <= 1'b1;
            end else if (T7) begin
                case (state)
                    ST_IDLE: begin
                        if (RUN)
                            state <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        op_q  <= IR_OP;
                        zf_q  <= ZF;
                        state <= ST_EXEC;
                    end
                    ST_EXEC: begin
                        cnt   <= cnt + CNT_W'(1);
                        state <= (op_q == OP_W'(OPC_HLT)) ? ST_HALT : ST_FETCH;
                    end
                    default: state <= ST_HALT;
                endcase
            end
        end
    end

    op_decode #(
        .OP_W   (OP_W)
    ) u_dec (
        .state  (state),
        .opcode (op_q),
        .zf     (zf_q),
        .beat   (beat),
        .strobe (dec)
    );

    // A malformed beat in the current cycle is also suppressed, so no strobe
    // fires on an ambiguous beat before the sticky flag is set.
    assign strobe = (err || !beat_ok) ? STROBE_NONE : dec;

    assign PC_OE     = strobe.pc_oe;
    assign PC_INC    = strobe.pc_inc;
    assign PC_LD     = strobe.pc_ld;
    assign MAR_LD    = strobe.mar_ld;
    assign MEM_RD    = strobe.mem_rd;
    assign MEM_WR    = strobe.mem_wr;
    assign IR_LD     = strobe.ir_ld;
    assign ACC_LD    = strobe.acc_ld;
    assign ALU_OP    = strobe.alu_op;
    assign CYCLE     = state;
    assign HALTED    = (state == ST_HALT);
    assign PHASE_ERR = err;
    assign INSTR_CNT = cnt;

endmodule

// File: tb/tb_cycle_ctrl.sv
// tb/tb_cycle_ctrl.sv - self-checking bench for cycle_ctrl
module tb_cycle_ctrl;

    localparam logic [9:0] B_NONE  = 10'h000;
    localparam logic [9:0] B_PCOE  = 10'h200;
    localparam logic [9:0] B_PCINC = 10'h100;
    localparam logic [9:0] B_PCLD  = 10'h080;
    localparam logic [9:0] B_MAR   = 10'h040;
    localparam logic [9:0] B_RD    = 10'h020;
    localparam logic [9:0] B_WR    = 10'h010;
    localparam logic [9:0] B_IRLD  = 10'h008;
    localparam logic [9:0] B_ACC   = 10'h004;
    localparam logic [9:0] A_ADD   = 10'h001;
    localparam logic [9:0] A_SUB   = 10'h002;

    typedef struct {
        logic       run;
        logic [3:0] op;
        logic       zf;
        logic [1:0] cyc;
        logic [7:0] cnt;
        logic [9:0] s0;
        logic [9:0] s1;
        logic [9:0] s2;
    } round_t;

    logic       CLK = 1'b0;
    logic       CLRn = 1'b0;
    logic [7:0] tv = 8'h01;
    logic       RUN = 1'b0;
    logic [3:0] IR_OP = 4'h0;
    logic       ZF = 1'b0;
    logic       PC_OE, PC_INC, PC_LD, MAR_LD, MEM_RD, MEM_WR, IR_LD, ACC_LD;
    logic [1:0] ALU_OP;
    logic [1:0] CYCLE;
    logic       HALTED;
    logic       PHASE_ERR;
    logic [7:0] INSTR_CNT;
    logic [9:0] strobes;

    int checks = 0;
    int errors = 0;
    round_t vec [24];

    always #5 CLK = ~CLK;

    cycle_ctrl #(.OP_W(4), .CNT_W(8)) dut (
        .CLK(CLK), .CLRn(CLRn),
        .T0(tv[0]), .T1(tv[1]), .T2(tv[2]), .T3(tv[3]),
        .T4(tv[4]), .T5(tv[5]), .T6(tv[6]), .T7(tv[7]),
        .RUN(RUN), .IR_OP(IR_OP), .ZF(ZF),
        .PC_OE(PC_OE), .PC_INC(PC_INC), .PC_LD(PC_LD), .MAR_LD(MAR_LD),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .IR_LD(IR_LD), .ACC_LD(ACC_LD),
        .ALU_OP(ALU_OP), .CYCLE(CYCLE), .HALTED(HALTED),
        .PHASE_ERR(PHASE_ERR), .INSTR_CNT(INSTR_CNT)
    );

    assign strobes = {PC_OE, PC_INC, PC_LD, MAR_LD, MEM_RD, MEM_WR, IR_LD, ACC_LD, ALU_OP};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_beat(input int k);
        tv = 8'(1 << k);
    endtask

    task automatic do_reset();
        CLRn = 1'b0;
        RUN = 1'b0;
        set_beat(0);
        tick();
        CLRn = 1'b1;
    endtask

    // One full T0..T7 round with no checking.
    task automatic run_round(input logic [3:0] op, input logic run);
        IR_OP = op;
        RUN = run;
        for (int k = 0; k < 8; k++) begin
            set_beat(k);
            tick();
        end
    endtask

    function automatic round_t mk(input logic run, input logic [3:0] op, input logic zf,
                                  input logic [1:0] cyc, input logic [7:0] cnt,
                                  input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2);
        round_t r;
        r.run = run; r.op = op; r.zf = zf; r.cyc = cyc; r.cnt = cnt;
        r.s0 = s0; r.s1 = s1; r.s2 = s2;
        return r;
    endfunction

    function automatic round_t fetch(input logic [3:0] op, input logic zf, input logic [7:0] cnt);
        return mk(1'b0, op, zf, 2'b01, cnt, B_PCOE | B_MAR, B_RD | B_IRLD, B_PCINC);
    endfunction

    function automatic round_t exec(input logic zf, input logic [7:0] cnt,
                                    input logic [9:0] s0, input logic [9:0] s1);
        return mk(1'b1, 4'hA, zf, 2'b10, cnt, s0, s1, B_NONE);
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec[0]  = mk(1'b1, 4'h0, 1'b0, 2'b00, 8'd0, B_NONE, B_NONE, B_NONE);
        vec[1]  = fetch(4'h2, 1'b0, 8'd0);
        vec[2]  = exec(1'b0, 8'd0, B_MAR, B_RD | B_ACC | A_ADD);
        vec[3]  = fetch(4'h3, 1'b0, 8'd1);
        vec[4]  = exec(1'b0, 8'd1, B_MAR, B_RD | B_ACC | A_SUB);
        vec[5]  = fetch(4'h1, 1'b0, 8'd2);
        vec[6]  = exec(1'b0, 8'd2, B_MAR, B_RD | B_ACC);
        vec[7]  = fetch(4'h4, 1'b0, 8'd3);
        vec[8]  = exec(1'b0, 8'd3, B_MAR, B_WR);
        vec[9]  = fetch(4'h6, 1'b0, 8'd4);
        vec[10] = exec(1'b1, 8'd4, B_NONE, B_NONE);
        vec[11] = fetch(4'h6, 1'b1, 8'd5);
        vec[12] = exec(1'b0, 8'd5, B_PCLD, B_NONE);
        vec[13] = fetch(4'h5, 1'b0, 8'd6);
        vec[14] = exec(1'b0, 8'd6, B_PCLD, B_NONE);
        vec[15] = fetch(4'h7, 1'b0, 8'd7);
        vec[16] = exec(1'b0, 8'd7, B_NONE, B_NONE);
        vec[17] = fetch(4'h0, 1'b0, 8'd8);
        vec[18] = exec(1'b0, 8'd8, B_NONE, B_NONE);
        vec[19] = fetch(4'hF, 1'b0, 8'd9);
        vec[20] = exec(1'b0, 8'd9, B_NONE, B_NONE);
        vec[21] = mk(1'b0, 4'h0, 1'b0, 2'b11, 8'd10, B_NONE, B_NONE, B_NONE);
        vec[22] = mk(1'b1, 4'h0, 1'b0, 2'b11, 8'd10, B_NONE, B_NONE, B_NONE);
        vec[23] = mk(1'b0, 4'h0, 1'b0, 2'b11, 8'd10, B_NONE, B_NONE, B_NONE);

        // Reset state
        tick();
        tick();
        chk("rst_strobes", 32'(strobes), 32'(B_NONE));
        chk("rst_cycle", 32'(CYCLE), 32'd0);
        chk("rst_halted", 32'(HALTED), 32'd0);
        chk("rst_err", 32'(PHASE_ERR), 32'd0);
        chk("rst_cnt", 32'(INSTR_CNT), 32'd0);
        CLRn = 1'b1;

        // Program walk: every opcode, JZ both ways, halt with RUN toggling
        for (int r = 0; r < 24; r++) begin
            IR_OP = vec[r].op;
            ZF = vec[r].zf;
            RUN = vec[r].run;
            for (int k = 0; k < 8; k++) begin
                logic [9:0] es;
                es = (k == 0) ? vec[r].s0 : (k == 1) ? vec[r].s1 : (k == 2) ? vec[r].s2 : B_NONE;
                set_beat(k);
                #1;
                chk($sformatf("vec%0d_t%0d_strobes", r, k), 32'(strobes), 32'(es));
                chk($sformatf("vec%0d_t%0d_cycle", r, k), 32'(CYCLE), 32'(vec[r].cyc));
                if (k == 0) begin
                    chk($sformatf("vec%0d_halted", r), 32'(HALTED), 32'(vec[r].cyc == 2'b11));
                    chk($sformatf("vec%0d_cnt", r), 32'(INSTR_CNT), 32'(vec[r].cnt));
                    chk($sformatf("vec%0d_err", r), 32'(PHASE_ERR), 32'd0);
                end
                tick();
            end
        end

        // Phase error: T2+T3 together in FETCH
        do_reset();
        run_round(4'h0, 1'b1);
        RUN = 1'b0;
        set_beat(0);
        #1;
        chk("perr_pre_t0", 32'(strobes), 32'(B_PCOE | B_MAR));
        tick();
        set_beat(1);
        tick();
        tv = 8'b0000_1100;
        tick();
        for (int k = 0; k < 16; k++) begin
            set_beat(k % 8);
            RUN = 1'b1;
            #1;
            chk($sformatf("perr_flag_%0d", k), 32'(PHASE_ERR), 32'd1);
            chk($sformatf("perr_strobes_%0d", k), 32'(strobes), 32'(B_NONE));
            chk($sformatf("perr_cycle_%0d", k), 32'(CYCLE), 32'd1);
            tick();
        end
        chk("perr_cnt", 32'(INSTR_CNT), 32'd0);
        CLRn = 1'b0;
        #1;
        chk("perr_clr_flag", 32'(PHASE_ERR), 32'd0);
        chk("perr_clr_cycle", 32'(CYCLE), 32'd0);
        tick();
        CLRn = 1'b1;

        // Counter wrap and asynchronous reset mid-FETCH
        do_reset();
        run_round(4'h0, 1'b1);
        for (int i = 1; i <= 257; i++) begin
            run_round(4'h0, 1'b0);
            run_round(4'hA, 1'b0);
            if (i == 255) chk("wrap_255", 32'(INSTR_CNT), 32'd255);
            if (i == 256) chk("wrap_0", 32'(INSTR_CNT), 32'd0);
        end
        chk("wrap_1", 32'(INSTR_CNT), 32'd1);
        chk("wrap_cycle", 32'(CYCLE), 32'd1);
        set_beat(0);
        tick();
        set_beat(1);
        #1;
        chk("midrst_pre", 32'(strobes), 32'(B_RD | B_IRLD));
        CLRn = 1'b0;
        #1;
        chk("midrst_strobes", 32'(strobes), 32'(B_NONE));
        chk("midrst_cycle", 32'(CYCLE), 32'd0);
        chk("midrst_cnt", 32'(INSTR_CNT), 32'd0);
        chk("midrst_halted", 32'(HALTED), 32'd0);
        chk("midrst_err", 32'(PHASE_ERR), 32'd0);
        tick();
        CLRn = 1'b1;
        run_round(4'h0, 1'b1);
        set_beat(0);
        #1;
        chk("restart_cycle", 32'(CYCLE), 32'd1);
        chk("restart_t0", 32'(strobes), 32'(B_PCOE | B_MAR));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cycle_ctrl.md
CYCLE_CTRL -- requirements
Module: cycle_ctrl

Interface
REQ-001 Parameter: OP_W, default 4, opcode width.
REQ-002 Parameter: CNT_W, default 8, instruction-counter width.
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 CLRn  input  1  asynchronous, active-low reset.
REQ-005 T0..T7  input  1 each  one-hot beat pulses from the 8-phase beat generator; exactly one high per cycle.
REQ-006 RUN  input  1  start request; sampled only in IDLE.
REQ-007 IR_OP  input  OP_W  opcode field of the instruction register.
REQ-008 ZF  input  1  accumulator zero flag.
REQ-009 PC_OE, PC_INC, PC_LD  output  1 each  PC drive to bus, increment, load.
REQ-010 MAR_LD, MEM_RD, MEM_WR, IR_LD, ACC_LD  output  1 each  register/memory strobes.
REQ-011 ALU_OP  output  2  00 PASS, 01 ADD, 10 SUB, 11 reserved.
REQ-012 CYCLE  output  2  machine state: 00 IDLE, 01 FETCH, 10 EXEC, 11 HALT.
REQ-013 HALTED  output  1  high in HALT.
REQ-014 PHASE_ERR  output  1  sticky beat-encoding error flag.
REQ-015 INSTR_CNT  output  CNT_W  count of completed EXEC cycles.

Function
REQ-016 State register changes only on a rising CLK edge where T7=1 (machine-cycle boundary); the new state is active from the following T0.
REQ-017 Transitions: IDLE->FETCH if RUN=1; FETCH->EXEC always; EXEC->HALT if latched opcode is HLT (0xF), else EXEC->FETCH; HALT is left only by reset.
REQ-018 Internal opcode register loads IR_OP and zero-flag register loads ZF on the T7 edge ending FETCH; both hold through EXEC.
REQ-019 Control outputs are combinational from state, latched opcode, latched ZF and T0..T7; zero latency relative to the beat.
REQ-020 FETCH beats: T0 PC_OE+MAR_LD; T1 MEM_RD+IR_LD; T2 PC_INC; T3-T7 no strobes.
REQ-021 EXEC LDA 0x1: T0 MAR_LD; T1 MEM_RD+ACC_LD, ALU_OP=PASS.
REQ-022 EXEC ADD 0x2 / SUB 0x3: T0 MAR_LD; T1 MEM_RD+ACC_LD, ALU_OP=ADD/SUB.
REQ-023 EXEC STA 0x4: T0 MAR_LD; T1 MEM_WR.
REQ-024 EXEC JMP 0x5: T0 PC_LD; JZ 0x6: T0 PC_LD only if latched ZF=1.
REQ-025 NOP 0x0, HLT 0xF and all undefined opcodes: no strobes in EXEC.
REQ-026 ALU_OP=PASS whenever not specified; IDLE and HALT assert no strobes.
REQ-027 INSTR_CNT increments on each T7 edge ending EXEC (including HLT); wraps max->0.
REQ-028 Beat check each edge: zero or >1 of T0..T7 high sets PHASE_ERR; PHASE_ERR holds until reset, forces all strobes to 0 and freezes state and INSTR_CNT.
REQ-029 RUN changes outside IDLE are ignored.

Reset
REQ-030 CLRn low asynchronously sets state IDLE, opcode 0, ZF latch 0, INSTR_CNT 0, PHASE_ERR 0; all strobes 0, CYCLE=00, HALTED=0.
REQ-031 Reset mid-instruction aborts with no further strobes; operation restarts from IDLE after CLRn release.

Structure
REQ-032 Package cycle_pkg holds state encoding, opcode constants, ALU_OP codes.
REQ-033 Sub-module op_decode maps (state, opcode, ZF latch, beat index) to the strobe vector; cycle_ctrl holds state, latches, counter and beat checker.

Verification
REQ-034 Reset, RUN=1 over one T0-T7 round -> CYCLE 00->01; T0 PC_OE+MAR_LD, T1 MEM_RD+IR_LD, T2 PC_INC.
REQ-035 IR_OP=0x2 fetched -> EXEC T1 MEM_RD+ACC_LD, ALU_OP=01; INSTR_CNT 0->1 at EXEC T7.
REQ-036 JZ with ZF=0 then ZF=1 at FETCH T7 -> PC_LD absent, then present at EXEC T0.
REQ-037 IR_OP=0xF -> after EXEC T7 CYCLE=11, HALTED=1, no strobes for 3 rounds despite RUN toggling.
REQ-038 Force T2+T3 high for one cycle -> PHASE_ERR=1 next edge, strobes 0, state frozen until CLRn pulse.
REQ-039 Preload INSTR_CNT at 255 via 255 NOPs, one more -> 0; CLRn low at FETCH T1 -> all outputs 0 immediately.
